operand_fetch_stage: RTL and testbench

//  ID/EX stage of the swt16 pipeline, directly upstream of the EX ALU.
//  - Drives the regfile read indices and receives its async read data.
//  - Resolves RAW hazards by bypass from EX/MEM/WB, or by stall (load-use, scoreboard).
//  - Registers operands plus control into the ID/EX pipeline register, using a valid/ready handshake.

---
 rtl/swt16_pkg.sv | 17 +
 rtl/operand_bypass_mux.sv | 50 +++++
 rtl/operand_fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/swt16_pkg.sv
// Shared swt16 pipeline types: default widths, word/index typedefs and the
// operand bypass source encoding.
package swt16_pkg;
    localparam int WORD_WIDTH = 16;
    localparam int IDX_WIDTH  = 4;

    typedef logic [IDX_WIDTH-1:0]  reg_idx_t;
    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        BYP_ZERO,
        BYP_EX,
        BYP_MEM,
        BYP_WB,
        BYP_RF
    } byp_sel_t;
endpackage

// File: rtl/operand_bypass_mux.sv
// Operand bypass for one source: picks zero / EX / MEM / WB / regfile by
// fixed priority and muxes the selected word.
module operand_bypass_mux #(
    parameter int WORD_WIDTH = swt16_pkg::WORD_WIDTH,
    parameter int IDX_WIDTH  = swt16_pkg::IDX_WIDTH
) (
    input  logic [IDX_WIDTH-1:0]  src_idx,
    input  logic                  use_src,
    input  logic                  ex_wr,
    input  logic [IDX_WIDTH-1:0]  ex_dst_idx,
    input  logic [WORD_WIDTH-1:0] ex_result,
    input  logic                  mem_wr,
    input  logic [IDX_WIDTH-1:0]  mem_dst_idx,
    input  logic [WORD_WIDTH-1:0] mem_result,
    input  logic                  wb_wr,
    input  logic [IDX_WIDTH-1:0]  wb_dst_idx,
    input  logic [WORD_WIDTH-1:0] wb_result,
    input  logic [WORD_WIDTH-1:0] rf_data,
    output logic [WORD_WIDTH-1:0] operand
);
    import swt16_pkg::*;

    byp_sel_t sel;

    always_comb begin
        sel = BYP_RF;
        if (!use_src || src_idx == '0) begin
            sel = BYP_ZERO;
        end else if (ex_wr && ex_dst_idx == src_idx) begin
            sel = BYP_EX;
        end else if (mem_wr && mem_dst_idx == src_idx) begin
            sel = BYP_MEM;
        end else if (wb_wr && wb_dst_idx == src_idx) begin
            // Regfile write lands at the clock edge, so the same-cycle read is stale.
            sel = BYP_WB;
        end
    end

    always_comb begin
        operand = '0;
        case (sel)
            BYP_ZERO: operand = '0;
            BYP_EX:   operand = ex_result;
            BYP_MEM:  operand = mem_result;
            BYP_WB:   operand = wb_result;
            BYP_RF:   operand = rf_data;
            default:  operand = '0;
        endcase
    end
endmodule

// File: rtl/operand_fetch_stage.sv
// swt16 ID/EX stage: operand bypass, RAW hazard stall and the ID/EX register.
// Build option FORWARDING_EN: full EX/MEM/WB bypass; undefined: WB bypass plus pending-write scoreboard.
module operand_fetch_stage #(
    parameter int WORD_WIDTH = swt16_pkg::WORD_WIDTH,
    parameter int IDX_WIDTH  = swt16_pkg::IDX_WIDTH,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_WIDTH-1:0]  in_src1_idx,
    input  logic [IDX_WIDTH-1:0]  in_src2_idx,
    input  logic                  in_use_src1,
    input  logic                  in_use_src2,
    input  logic [IDX_WIDTH-1:0]  in_dst_idx,
    input  logic                  in_dst_wr,
    input  logic                  in_is_load,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic [IDX_WIDTH-1:0]  rf_src1_idx,
    output logic [IDX_WIDTH-1:0]  rf_src2_idx,
    input  logic [WORD_WIDTH-1:0] rf_src1,
    input  logic [WORD_WIDTH-1:0] rf_src2,
    input  logic [WORD_WIDTH-1:0] ex_result,
    input  logic                  mem_wr,
    input  logic [IDX_WIDTH-1:0]  mem_dst_idx,
    input  logic [WORD_WIDTH-1:0] mem_result,
    input  logic                  wb_wr,
    input  logic [IDX_WIDTH-1:0]  wb_dst_idx,
    input  logic [WORD_WIDTH-1:0] wb_result,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_op1,
    output logic [WORD_WIDTH-1:0] out_op2,
    output logic [IDX_WIDTH-1:0]  out_dst_idx,
    output logic                  out_dst_wr,
    output logic                  out_is_load,
    output logic [CTRL_WIDTH-1:0] out_ctrl
);
    import swt16_pkg::*;

`ifdef FORWARDING_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
    logic [IDX_WIDTH-1:0]  out_dst_idx_q, out_dst_idx_d;
    logic                  out_dst_wr_q, out_dst_wr_d;
    logic                  out_is_load_q, out_is_load_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;

    logic [WORD_WIDTH-1:0] op1, op2;
    logic                  ex_byp_wr, mem_byp_wr;
    logic                  used1, used2, load_use, sb_stall, capture;

    assign rf_src1_idx = in_src1_idx;
    assign rf_src2_idx = in_src2_idx;

    // A load in the out register has no EX result yet; it must not bypass from EX.
    assign ex_byp_wr  = FWD_ON & out_valid_q & out_dst_wr_q & ~out_is_load_q;
    assign mem_byp_wr = FWD_ON & mem_wr;

    operand_bypass_mux #(.WORD_WIDTH(WORD_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_byp1 (
        .src_idx(in_src1_idx), .use_src(in_use_src1),
        .ex_wr(ex_byp_wr), .ex_dst_idx(out_dst_idx_q), .ex_result(ex_result),
        .mem_wr(mem_byp_wr), .mem_dst_idx(mem_dst_idx), .mem_result(mem_result),
        .wb_wr(wb_wr), .wb_dst_idx(wb_dst_idx), .wb_result(wb_result),
        .rf_data(rf_src1), .operand(op1)
    );

    operand_bypass_mux #(.WORD_WIDTH(WORD_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_byp2 (
        .src_idx(in_src2_idx), .use_src(in_use_src2),
        .ex_wr(ex_byp_wr), .ex_dst_idx(out_dst_idx_q), .ex_result(ex_result),
        .mem_wr(mem_byp_wr), .mem_dst_idx(mem_dst_idx), .mem_result(mem_result),
        .wb_wr(wb_wr), .wb_dst_idx(wb_dst_idx), .wb_result(wb_result),
        .rf_data(rf_src2), .operand(op2)
    );

    assign used1 = in_use_src1 & (in_src1_idx != '0);
    assign used2 = in_use_src2 & (in_src2_idx != '0);

    assign load_use = FWD_ON & out_valid_q & out_is_load_q & out_dst_wr_q & (out_dst_idx_q != '0) &
                      ((used1 & (in_src1_idx == out_dst_idx_q)) | (used2 & (in_src2_idx == out_dst_idx_q)));

    assign in_ready = ~flush & ~load_use & ~sb_stall & (~out_valid_q | out_ready);
    assign capture  = in_valid & in_ready;

`ifdef FORWARDING_EN
    assign sb_stall = 1'b0;
`else
    localparam int NREG = 2 ** IDX_WIDTH;

    logic [NREG-1:0] pend_q, pend_d;

    // A WB write to the source in this cycle is bypassed, so it need not stall.
    assign sb_stall = (used1 & pend_q[in_src1_idx] & ~(wb_wr & (wb_dst_idx == in_src1_idx))) |
                      (used2 & pend_q[in_src2_idx] & ~(wb_wr & (wb_dst_idx == in_src2_idx)));

    always_comb begin
        pend_d = pend_q;
        if (wb_wr) pend_d[wb_dst_idx] = 1'b0;
        if (flush && out_valid_q && out_dst_wr_q) pend_d[out_dst_idx_q] = 1'b0;
        if (capture && in_dst_wr) pend_d[in_dst_idx] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end
`endif

    always_comb begin
        out_valid_d   = out_valid_q;
        out_op1_d     = out_op1_q;
        out_op2_d     = out_op2_q;
        out_dst_idx_d = out_dst_idx_q;
        out_dst_wr_d  = out_dst_wr_q;
        out_is_load_d = out_is_load_q;
        out_ctrl_d    = out_ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d   = 1'b1;
            out_op1_d     = op1;
            out_op2_d     = op2;
            out_dst_idx_d = in_dst_idx;
            out_dst_wr_d  = in_dst_wr;
            out_is_load_d = in_is_load;
            out_ctrl_d    = in_ctrl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_dst_idx_q <= '0;
            out_dst_wr_q  <= 1'b0;
            out_is_load_q <= 1'b0;
            out_ctrl_q    <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_op1_q     <= out_op1_d;
            out_op2_q     <= out_op2_d;
            out_dst_idx_q <= out_dst_idx_d;
            out_dst_wr_q  <= out_dst_wr_d;
            out_is_load_q <= out_is_load_d;
            out_ctrl_q    <= out_ctrl_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_dst_idx = out_dst_idx_q;
    assign out_dst_wr  = out_dst_wr_q;
    assign out_is_load = out_is_load_q;
    assign out_ctrl    = out_ctrl_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: reference-model checks every cycle,
// a vector table for operand selection, hand sequences for stalls/hold/flush/reset.
module tb_operand_fetch_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  in_src1_idx, in_src2_idx, in_dst_idx;
    logic        in_use_src1, in_use_src2, in_dst_wr, in_is_load;
    logic [7:0]  in_ctrl;
    logic [3:0]  rf_src1_idx, rf_src2_idx;
    logic [15:0] rf_src1, rf_src2, ex_result;
    logic        mem_wr, wb_wr, flush, out_valid, out_ready;
    logic [3:0]  mem_dst_idx, wb_dst_idx, out_dst_idx;
    logic [15:0] mem_result, wb_result, out_op1, out_op2;
    logic        out_dst_wr, out_is_load;
    logic [7:0]  out_ctrl;

    operand_fetch_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1_idx(in_src1_idx), .in_src2_idx(in_src2_idx),
        .in_use_src1(in_use_src1), .in_use_src2(in_use_src2),
        .in_dst_idx(in_dst_idx), .in_dst_wr(in_dst_wr), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
        .rf_src1_idx(rf_src1_idx), .rf_src2_idx(rf_src2_idx), .rf_src1(rf_src1), .rf_src2(rf_src2),
        .ex_result(ex_result),
        .mem_wr(mem_wr), .mem_dst_idx(mem_dst_idx), .mem_result(mem_result),
        .wb_wr(wb_wr), .wb_dst_idx(wb_dst_idx), .wb_result(wb_result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_dst_idx(out_dst_idx),
        .out_dst_wr(out_dst_wr), .out_is_load(out_is_load), .out_ctrl(out_ctrl)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: what the ID/EX register should hold, and which registers await a write.
    logic        m_valid, m_wr, m_load;
    logic [15:0] m_op1, m_op2;
    logic [3:0]  m_dst;
    logic [7:0]  m_ctrl;
    bit          m_pend[16];
    logic        exp_ready, last_in_ready;
    logic [15:0] exp_op1, exp_op2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] resolve(input logic [3:0] idx, input logic use_it, input logic [15:0] rf);
        if (!use_it || idx == 0) return 16'h0;
`ifdef FORWARDING_EN
        if (m_valid && m_wr && !m_load && m_dst == idx) return ex_result;
        if (mem_wr && mem_dst_idx == idx) return mem_result;
`endif
        if (wb_wr && wb_dst_idx == idx) return wb_result;
        return rf;
    endfunction

    function automatic bit busy(input logic [3:0] idx, input logic use_it);
        if (!use_it || idx == 0) return 1'b0;
`ifdef FORWARDING_EN
        return m_valid && m_load && m_wr && m_dst == idx;
`else
        return m_pend[idx] && !(wb_wr && wb_dst_idx == idx);
`endif
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wr = 0; m_load = 0; m_op1 = 0; m_op2 = 0; m_dst = 0; m_ctrl = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic model_comb();
        exp_op1   = resolve(in_src1_idx, in_use_src1, rf_src1);
        exp_op2   = resolve(in_src2_idx, in_use_src2, rf_src2);
        exp_ready = !flush && !busy(in_src1_idx, in_use_src1) && !busy(in_src2_idx, in_use_src2)
                    && (!m_valid || out_ready);
    endtask

    task automatic model_edge();
        bit cap;
        cap = in_valid && exp_ready;
        if (wb_wr) m_pend[wb_dst_idx] = 0;
        if (flush && m_valid && m_wr) m_pend[m_dst] = 0;
        if (cap && in_dst_wr && in_dst_idx != 0) m_pend[in_dst_idx] = 1;
        if (flush) m_valid = 0;
        else if (cap) begin
            m_valid = 1; m_op1 = exp_op1; m_op2 = exp_op2;
            m_dst = in_dst_idx; m_wr = in_dst_wr; m_load = in_is_load; m_ctrl = in_ctrl;
        end else if (out_ready) m_valid = 0;
    endtask

    // Called just after a falling edge with inputs set; returns just after the next falling edge.
    task automatic step();
        #1;
        model_comb();
        last_in_ready = in_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("rf_idx", {24'd0, rf_src1_idx, rf_src2_idx}, {24'd0, in_src1_idx, in_src2_idx});
        @(posedge clock);
        model_edge();
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_ops", {out_op1, out_op2}, {m_op1, m_op2});
        chk("out_fields", {18'd0, out_dst_idx, out_dst_wr, out_is_load, out_ctrl},
            {18'd0, m_dst, m_wr, m_load, m_ctrl});
        @(negedge clock);
    endtask

    task automatic set_idle();
        in_valid = 0; in_src1_idx = 0; in_src2_idx = 0; in_use_src1 = 0; in_use_src2 = 0;
        in_dst_idx = 0; in_dst_wr = 0; in_is_load = 0; in_ctrl = 0;
        rf_src1 = 0; rf_src2 = 0; ex_result = 0;
        mem_wr = 0; mem_dst_idx = 0; mem_result = 0;
        wb_wr = 0; wb_dst_idx = 0; wb_result = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [3:0] s1, input logic u1, input logic [3:0] d,
                         input logic dwr, input logic ld, input logic [7:0] c);
        in_valid = 1; in_src1_idx = s1; in_use_src1 = u1; in_src2_idx = 0; in_use_src2 = 0;
        in_dst_idx = d; in_dst_wr = dwr; in_is_load = ld; in_ctrl = c;
    endtask

    typedef struct {
        logic [3:0]  s1; logic u1; logic [3:0] s2; logic u2;
        logic [15:0] rf1, rf2;
        logic        mw; logic [3:0] md; logic [15:0] mr;
        logic        ww; logic [3:0] wd; logic [15:0] wr;
        logic [15:0] e1, e2;
    } vec_t;

`ifdef FORWARDING_EN
    localparam logic [15:0] R4_EXP = 16'h1111;
    localparam logic [15:0] R8_EXP = 16'h8888;
`else
    localparam logic [15:0] R4_EXP = 16'h2222;
    localparam logic [15:0] R8_EXP = 16'h0808;
`endif

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'd3, 1'b1, 4'd5, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 16'hAAAA, 16'h5555};
        vecs[1] = '{4'd0, 1'b1, 4'd6, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 4'd0, 16'h1111, 1'b1, 4'd0, 16'h2222, 16'h0000, 16'h0000};
        vecs[2] = '{4'd2, 1'b1, 4'd7, 1'b1, 16'h0002, 16'h0000, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h00A5, 16'h0002, 16'h00A5};
        vecs[3] = '{4'd4, 1'b1, 4'd4, 1'b1, 16'h3333, 16'h3333, 1'b1, 4'd4, 16'h1111, 1'b1, 4'd4, 16'h2222, R4_EXP, R4_EXP};
        vecs[4] = '{4'd9, 1'b1, 4'd8, 1'b1, 16'h0909, 16'h0808, 1'b1, 4'd8, 16'h8888, 1'b1, 4'd9, 16'h9999, 16'h9999, R8_EXP};
        vecs[5] = '{4'd10, 1'b1, 4'd0, 1'b0, 16'h0A0A, 16'h0000, 1'b0, 4'd10, 16'hBBBB, 1'b0, 4'd0, 16'h0, 16'h0A0A, 16'h0000};

        set_idle();
        model_reset();
        reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_data", {out_op1, out_op2}, 32'd0);
        chk("reset_fields", {18'd0, out_dst_idx, out_dst_wr, out_is_load, out_ctrl}, 32'd0);
        reset = 0;
        step();

        // Operand selection table; every entry writes r0 so the EX path also targets r0.
        foreach (vecs[i]) begin
            set_idle();
            in_valid = 1; in_dst_idx = 0; in_dst_wr = 1; in_ctrl = 8'(i);
            in_src1_idx = vecs[i].s1; in_use_src1 = vecs[i].u1;
            in_src2_idx = vecs[i].s2; in_use_src2 = vecs[i].u2;
            rf_src1 = vecs[i].rf1; rf_src2 = vecs[i].rf2; ex_result = 16'hEEEE;
            mem_wr = vecs[i].mw; mem_dst_idx = vecs[i].md; mem_result = vecs[i].mr;
            wb_wr = vecs[i].ww; wb_dst_idx = vecs[i].wd; wb_result = vecs[i].wr;
            step();
            chk($sformatf("vec%0d_op1", i), {16'd0, out_op1}, {16'd0, vecs[i].e1});
            chk($sformatf("vec%0d_op2", i), {16'd0, out_op2}, {16'd0, vecs[i].e2});
        end

`ifdef FORWARDING_EN
        // EX bypass with no stall.
        set_idle(); issue(0, 0, 3, 1, 0, 8'h01); step();
        set_idle(); issue(3, 1, 0, 0, 0, 8'h02); rf_src1 = 16'hDEAD; ex_result = 16'h1234; step();
        chk("ex_byp_ready", {31'd0, last_in_ready}, 32'd1);
        chk("ex_byp_op1", {16'd0, out_op1}, 32'h1234);
        // Load-use: one stall, one bubble, then MEM bypass.
        set_idle(); issue(0, 0, 5, 1, 1, 8'h03); step();
        set_idle(); issue(5, 1, 0, 0, 0, 8'h04); step();
        chk("ld_use_stall", {31'd0, last_in_ready}, 32'd0);
        chk("ld_use_bubble", {31'd0, out_valid}, 32'd0);
        mem_wr = 1; mem_dst_idx = 5; mem_result = 16'hBEEF; step();
        chk("ld_use_ready", {31'd0, last_in_ready}, 32'd1);
        chk("ld_use_op1", {16'd0, out_op1}, 32'hBEEF);
`else
        // Scoreboard: consumer of r9 waits until WB writes r9.
        set_idle(); issue(0, 0, 9, 1, 0, 8'h05); step();
        set_idle(); issue(9, 1, 0, 0, 0, 8'h06); rf_src1 = 16'h0BAD;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sb_stall", {31'd0, last_in_ready}, 32'd0);
        end
        wb_wr = 1; wb_dst_idx = 9; wb_result = 16'h9A9A; step();
        chk("sb_release", {31'd0, last_in_ready}, 32'd1);
        chk("sb_wb_op1", {16'd0, out_op1}, 32'h9A9A);
`endif

        // Backpressure hold, then flush of the held producer of r12.
        set_idle(); issue(1, 1, 12, 1, 0, 8'hC3); rf_src1 = 16'h0C0C; step();
        set_idle(); issue(2, 1, 0, 0, 0, 8'h07); rf_src1 = 16'h5A5A; out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_in_ready", {31'd0, last_in_ready}, 32'd0);
            chk("hold_op1", {15'd0, out_valid, out_op1}, {15'd0, 1'b1, 16'h0C0C});
            chk("hold_ctrl", {24'd0, out_ctrl}, 32'hC3);
        end
        flush = 1; step();
        chk("flush_in_ready", {31'd0, last_in_ready}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        set_idle(); issue(12, 1, 0, 0, 0, 8'h08); rf_src1 = 16'h7777; step();
        chk("flush_unblock", {31'd0, last_in_ready}, 32'd1);
        chk("flush_op1", {16'd0, out_op1}, 32'h7777);

        // Reset mid-operation clears at once, including pending writes.
        set_idle(); issue(0, 0, 6, 1, 0, 8'h09); step();
        #2 reset = 1;
        #1;
        chk("async_reset", {15'd0, out_valid, out_op1}, 32'd0);
        model_reset();
        @(negedge clock);
        reset = 0;
        set_idle(); issue(6, 1, 0, 0, 0, 8'h0A); rf_src1 = 16'h6666; step();
        chk("reset_clears_sb", {15'd0, last_in_ready, out_op1}, {15'd0, 1'b1, 16'h6666});

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_src1_idx = 4'($urandom_range(0, 7));
            in_src2_idx = 4'($urandom_range(0, 7));
            in_use_src1 = 1'($urandom);
            in_use_src2 = 1'($urandom);
            in_dst_idx  = 4'($urandom_range(0, 7));
            in_dst_wr   = 1'($urandom);
            in_is_load  = ($urandom_range(0, 3) == 0);
            in_ctrl     = 8'($urandom);
            rf_src1     = 16'($urandom);
            rf_src2     = 16'($urandom);
            ex_result   = 16'($urandom);
            mem_wr      = 1'($urandom);
            mem_dst_idx = 4'($urandom_range(0, 7));
            mem_result  = 16'($urandom);
            wb_wr       = ($urandom_range(0, 9) < 4);
            wb_dst_idx  = 4'($urandom_range(0, 7));
            wb_result   = 16'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
